// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : 5-stage MIPS decode, control pipeline, hazard and forwarding unit.
//            Define PIPE_FORWARD_EN to build the EX-stage forwarding unit.
// Revision : 1.0
// ============================================================================
module pipe_ctrl_unit #(
  parameter int INST_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INST_W-1:0]   inst_id,
  input  logic                inst_valid,
  input  logic                br_eq_ex,
  output logic                ex_alu_src,
  output logic                ex_reg_dst,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [REG_AW-1:0]   wb_dst,
  output logic                stall,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic [1:0]          pc_sel,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                illegal
);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_NO  = ALU_OP_W'(7);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;

  // rs/rt hold 0 when the instruction does not read that operand, so a
  // zero source can never match a producer.
  typedef struct packed {
    logic                alu_src;
    logic                reg_dst;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                branch;
    logic                is_bne;
    logic [REG_AW-1:0]   dst;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  function automatic idex_t bubble();
    idex_t b;
    b        = '0;
    b.alu_op = ALU_NO;
    return b;
  endfunction

  function automatic logic reads(input idex_t c, input logic [REG_AW-1:0] r);
    return (r != '0) && ((c.rs == r) || (c.rt == r));
  endfunction

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   illegal_q, illegal_d;

  idex_t               dec;
  logic                dec_jump;
  logic                dec_bad;
  logic [ALU_OP_W-1:0] r_op;
  logic                r_ok;
  logic                taken;
  logic                hazard;

  logic [5:0]        opc;
  logic [5:0]        funct;
  logic [REG_AW-1:0] f_rs, f_rt, f_rd;

  assign opc   = inst_id[31:26];
  assign funct = inst_id[5:0];
  assign f_rs  = REG_AW'(inst_id[25:21]);
  assign f_rt  = REG_AW'(inst_id[20:16]);
  assign f_rd  = REG_AW'(inst_id[15:11]);

  always_comb begin
    r_op = ALU_NO;
    r_ok = 1'b1;
    case (funct)
      6'b100000: r_op = ALU_ADD;
      6'b100010: r_op = ALU_SUB;
      6'b100100: r_op = ALU_AND;
      6'b100101: r_op = ALU_OR;
      6'b101010: r_op = ALU_SLT;
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec      = bubble();
    dec_jump = 1'b0;
    dec_bad  = 1'b0;
    if (inst_valid) begin
      case (opc)
        OPC_RTYPE: if (r_ok) begin
          dec.alu_op    = r_op;
          dec.reg_dst   = 1'b1;
          dec.reg_write = 1'b1;
          dec.dst       = f_rd;
          dec.rs        = f_rs;
          dec.rt        = f_rt;
        end
        OPC_LW: begin
          dec.alu_op     = ALU_ADD;
          dec.alu_src    = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.dst        = f_rt;
          dec.rs         = f_rs;
        end
        OPC_SW: begin
          dec.alu_op    = ALU_ADD;
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.rs        = f_rs;
          dec.rt        = f_rt;
        end
        OPC_ADDI: begin
          dec.alu_op    = ALU_ADD;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.dst       = f_rt;
          dec.rs        = f_rs;
        end
        OPC_BEQ, OPC_BNE: begin
          dec.alu_op = ALU_SUB;
          dec.branch = 1'b1;
          dec.is_bne = (opc == OPC_BNE);
          dec.rs     = f_rs;
          dec.rt     = f_rt;
        end
        OPC_J:   dec_jump = 1'b1;
        default: dec_bad  = 1'b1;
      endcase
    end
  end

  assign taken = idex_q.branch & (br_eq_ex ^ idex_q.is_bne);

`ifdef PIPE_FORWARD_EN
  assign hazard = idex_q.mem_read && reads(dec, idex_q.dst);
`else
  // Without forwarding every producer must reach MEM/WB before the consumer
  // leaves ID; the regfile's write-before-read covers the last stage.
  assign hazard = (idex_q.reg_write  && reads(dec, idex_q.dst)) ||
                  (exmem_q.reg_write && reads(dec, exmem_q.dst));
`endif

  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    pc_sel     = 2'd0;
    idex_d     = dec;
    if (taken) begin
      pc_sel     = 2'd1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      idex_d     = bubble();
    end else if (dec_jump) begin
      pc_sel     = 2'd2;
      flush_ifid = 1'b1;
      idex_d     = bubble();
    end else if (hazard) begin
      stall  = 1'b1;
      idex_d = bubble();
    end
    if (!rst_n) begin
      stall      = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      pc_sel     = 2'd0;
    end
  end

`ifdef PIPE_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (exmem_q.reg_write && (exmem_q.dst != '0) && (exmem_q.dst == src))
      return 2'b10;
    else if (memwb_q.reg_write && (memwb_q.dst != '0) && (memwb_q.dst == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      fwd_a = fwd_sel(idex_q.rs);
      fwd_b = fwd_sel(idex_q.rt);
    end
  end
`else
  logic unused_srcs;
  assign unused_srcs = ^{idex_q.rs, idex_q.rt};
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  always_comb begin
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.dst        = idex_q.dst;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dst        = exmem_q.dst;
    illegal_d          = illegal_q | dec_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q    <= bubble();
      exmem_q   <= '0;
      memwb_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_reg_dst    = idex_q.reg_dst;
  assign ex_alu_op     = idex_q.alu_op;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_dst        = memwb_q.dst;
  assign illegal       = illegal_q;

  logic unused_fields;
  assign unused_fields = ^{inst_id[10:6]};

  generate
    if (INST_W > 32) begin : g_wide_inst
      logic unused_hi;
      assign unused_hi = ^inst_id[INST_W-1:32];
    end
  endgenerate

endmodule
`default_nettype wire
